// File: rtl/obuf_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : obuf_arb_pkg
// Purpose : Shared router definitions for the per-direction output stage.
//           Defines the direction indices, the number of requesting ports,
//           the default payload width and the index helper types.
// Config  : OBUF_LOCAL_PRIO_EN (used by rr_arb5 / obuf_arb, not here)
// Revision: 1.0 - initial release
// ============================================================================
package obuf_arb_pkg;

  // Requesting input buffers, index order N, W, S, E, local (B)
  localparam int DIR_N = 0;
  localparam int DIR_W = 1;
  localparam int DIR_S = 2;
  localparam int DIR_E = 3;
  localparam int DIR_B = 4;

  localparam int NPORT      = 5;
  localparam int PYLD_W_DEF = 23;
  localparam int IDX_W      = 3;

  typedef logic [IDX_W-1:0] port_idx_t;
  typedef logic [NPORT-1:0] port_vec_t;

  // Next round-robin start position: idx + 1, wrapping to 0 at modulus.
  function automatic port_idx_t idx_inc(input port_idx_t idx, input int modulus);
    if ((int'(idx) + 1) >= modulus) begin
      return '0;
    end
    return idx + port_idx_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/obuf_arb_rr_arb5.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb5
// Purpose : Combinational 5-way round-robin arbiter. Searches the request
//           vector starting at the rotation pointer, wrapping past the last
//           rotating port back to port 0; the first set bit wins.
// Ports   : i_req      - request vector, bit i = input port i
//           i_rr_ptr   - rotation start position
//           o_gnt      - one-hot grant, all-zero when no request
//           o_gnt_idx  - index of the granted port (0 when no grant)
// Config  : OBUF_LOCAL_PRIO_EN - local port (DIR_B) has strict priority and
//           the rotation covers only ports DIR_N..DIR_E.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arb5
  import obuf_arb_pkg::*;
(
  input  logic [NPORT-1:0] i_req,
  input  port_idx_t        i_rr_ptr,
  output logic [NPORT-1:0] o_gnt,
  output port_idx_t        o_gnt_idx
);

`ifdef OBUF_LOCAL_PRIO_EN
  // Only the four mesh directions take part in the rotation.
  localparam int RR_N = NPORT - 1;
`else
  localparam int RR_N = NPORT;
`endif

  always_comb begin
    logic w_found;
    int   w_slot;
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_slot    = 0;
`ifdef OBUF_LOCAL_PRIO_EN
    if (i_req[DIR_B]) begin
      o_gnt[DIR_B] = 1'b1;
      o_gnt_idx    = port_idx_t'(DIR_B);
      w_found      = 1'b1;
    end
`endif
    for (int k = 0; k < RR_N; k++) begin
      // i_rr_ptr is always below RR_N, so one subtraction is enough to wrap.
      w_slot = int'(i_rr_ptr) + k;
      if (w_slot >= RR_N) begin
        w_slot = w_slot - RR_N;
      end
      if (!w_found && i_req[w_slot]) begin
        o_gnt[w_slot] = 1'b1;
        o_gnt_idx     = w_slot[IDX_W-1:0];
        w_found       = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/obuf_arb.sv
`default_nettype none
// ============================================================================
// Module  : obuf_arb
// Purpose : Per-direction output stage of a mesh router node. Arbitrates
//           among the five input buffers requesting this output, captures
//           the granted payload into a small FIFO and drives the vld/rdy
//           link towards the neighbouring node or local sink.
// Ports   : clk        - clock, all state on rising edge
//           rst        - asynchronous reset, active-high
//           req        - bit i = input buffer i requests this output
//           payload_i  - port i payload at [i*PYLD_W +: PYLD_W]
//           gnt        - one-hot grant (combinational, independent of rdy)
//           obuf_rdy   - FIFO can accept one entry this cycle
//           obuf_vld   - link valid, FIFO not empty
//           link_rdy   - downstream ready
//           payload_o  - FIFO head payload
// Params  : PYLD_W - payload width, DEPTH - FIFO entries (power of 2, >= 2)
// Config  : OBUF_LOCAL_PRIO_EN - local port strictly wins over N/W/S/E and
//           does not advance the rotation pointer.
// Revision: 1.0 - initial release
// ============================================================================
module obuf_arb
  import obuf_arb_pkg::*;
#(
  parameter int PYLD_W = PYLD_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NPORT-1:0]        req,
  input  logic [NPORT*PYLD_W-1:0] payload_i,
  output logic [NPORT-1:0]        gnt,
  output logic                    obuf_rdy,
  output logic                    obuf_vld,
  input  logic                    link_rdy,
  output logic [PYLD_W-1:0]       payload_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [NPORT-1:0]  w_gnt;
  port_idx_t         w_gnt_idx;
  logic              w_push;
  logic              w_pop;
  logic [PYLD_W-1:0] w_pyld;

  port_idx_t         r_rr_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [PYLD_W-1:0] r_mem [DEPTH];

  rr_arb5 u_rr_arb5 (
    .i_req     (req),
    .i_rr_ptr  (r_rr_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign gnt = w_gnt;

  // Status is decoded from registered count only, so rdy never depends on
  // the same-cycle pop and there is no combinational path from link_rdy.
  assign obuf_rdy = (r_count != CNT_W'(DEPTH));
  assign obuf_vld = (r_count != '0);

  assign w_push = (|w_gnt) & obuf_rdy;
  assign w_pop  = obuf_vld & link_rdy;

  // Grant is one-hot, so an AND-OR mux selects the winning payload.
  always_comb begin
    w_pyld = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (w_gnt[i]) begin
        w_pyld = w_pyld | payload_i[i*PYLD_W +: PYLD_W];
      end
    end
  end

  assign payload_o = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      // Storage is cleared so the head reads zero out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_pyld;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
`ifdef OBUF_LOCAL_PRIO_EN
        // Local grants leave the mesh-direction rotation untouched.
        if (w_gnt_idx != port_idx_t'(DIR_B)) begin
          r_rr_ptr <= idx_inc(w_gnt_idx, NPORT - 1);
        end
`else
        r_rr_ptr <= idx_inc(w_gnt_idx, NPORT);
`endif
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(w_gnt));
  a_gnt_in_req  : assert property (@(posedge clk) disable iff (rst) ((w_gnt & ~req) == '0));
  a_no_ovf      : assert property (@(posedge clk) disable iff (rst)
                                   !(w_push && (r_count == CNT_W'(DEPTH))));
  a_no_udf      : assert property (@(posedge clk) disable iff (rst)
                                   !(w_pop && (r_count == '0)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_obuf_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_obuf_arb
// Purpose : Directed self-checking bench for obuf_arb (DEPTH=2, PYLD_W=23).
// Config  : OBUF_LOCAL_PRIO_EN selects the local-priority scenario.
// Revision: 1.0 - initial release
// ============================================================================
module tb_obuf_arb;

  localparam int PW = 23;
  localparam int D  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    req;
  logic [PW-1:0] p [5];
  logic [5*PW-1:0] payload_i;
  logic          link_rdy;
  logic [4:0]    gnt;
  logic          obuf_rdy;
  logic          obuf_vld;
  logic [PW-1:0] payload_o;

  int total = 0;
  int bad   = 0;

  assign payload_i = {p[4], p[3], p[2], p[1], p[0]};

  always #5 clk = ~clk;

  obuf_arb #(.PYLD_W(PW), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .payload_i (payload_i),
    .gnt       (gnt),
    .obuf_rdy  (obuf_rdy),
    .obuf_vld  (obuf_vld),
    .link_rdy  (link_rdy),
    .payload_o (payload_o)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seq3 [6];
    seq3 = '{0, 1, 2, 3, 4, 0};
    rst = 1'b1; req = '0; link_rdy = 1'b0;
    p[0] = 23'h10A0A0; p[1] = 23'h21B1B1; p[2] = 23'h32C2C2;
    p[3] = 23'h43D3D3; p[4] = 23'h54E4E4;

    // Reset values
    #1;
    check("rst_gnt", gnt, 5'b00000);
    check("rst_rdy", obuf_rdy, 1'b1);
    check("rst_vld", obuf_vld, 1'b0);
    check("rst_pyld", payload_o, 23'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Two requesters held: 0, 2, 0
    link_rdy = 1'b1;
    req = 5'b00101;
    #1;
    check("alt_g0", gnt, 5'b00001);
    tick();
    check("alt_g1", gnt, 5'b00100);
    check("alt_vld1", obuf_vld, 1'b1);
    check("alt_p1", payload_o, p[0]);
    tick();
    check("alt_g2", gnt, 5'b00001);
    check("alt_p2", payload_o, p[2]);
    tick();
    check("alt_p3", payload_o, p[0]);
    check("alt_vld3", obuf_vld, 1'b1);
    req = '0;
    tick();
    check("alt_drain_vld", obuf_vld, 1'b0);
    check("alt_drain_rdy", obuf_rdy, 1'b1);

    rst = 1'b1; #1; rst = 1'b0; #1;
`ifndef OBUF_LOCAL_PRIO_EN
    // All five request: full rotation with 4->0 wrap, push+pop at count 1
    req = 5'b11111;
    #1;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("rr_g%0d", k), gnt, 5'b00001 << seq3[k]);
      if (k > 0) begin
        check($sformatf("rr_p%0d", k), payload_o, p[seq3[k-1]]);
        check($sformatf("rr_vld%0d", k), obuf_vld, 1'b1);
        check($sformatf("rr_rdy%0d", k), obuf_rdy, 1'b1);
      end
      tick();
    end
    check("rr_p_last", payload_o, p[0]);
    req = '0;
    tick();
    check("rr_drain_vld", obuf_vld, 1'b0);
`else
    // Local port starves port 0 until it drops its request
    req = 5'b10001;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("lp_g%0d", k), gnt, 5'b10000);
      tick();
      check($sformatf("lp_p%0d", k), payload_o, p[4]);
    end
    req = 5'b00001;
    #1;
    check("lp_g_port0", gnt, 5'b00001);
    tick();
    req = '0;
    tick();
    tick();
    check("lp_drain_vld", obuf_vld, 1'b0);
`endif

    // Backpressure: fill to DEPTH, stall, then drain
    rst = 1'b1; #1; rst = 1'b0; #1;
    link_rdy = 1'b0;
    req = 5'b01110;
    #1;
    check("bp_g0", gnt, 5'b00010);
    check("bp_rdy0", obuf_rdy, 1'b1);
    tick();
    req = 5'b01100;
    #1;
    check("bp_g1", gnt, 5'b00100);
    check("bp_rdy1", obuf_rdy, 1'b1);
    check("bp_vld1", obuf_vld, 1'b1);
    check("bp_p1", payload_o, p[1]);
    tick();
    req = 5'b01000;
    #1;
    check("bp_rdy_full", obuf_rdy, 1'b0);
    check("bp_g_full", gnt, 5'b01000);
    check("bp_p_full", payload_o, p[1]);
    req = 5'b01001;
    #1;
    check("bp_g_ptr", gnt, 5'b01000);
    tick();
    check("bp_rdy_stall", obuf_rdy, 1'b0);
    check("bp_g_frozen", gnt, 5'b01000);
    check("bp_p_stall", payload_o, p[1]);
    link_rdy = 1'b1;
    #1;
    check("bp_rdy_nocomb", obuf_rdy, 1'b0);
    tick();
    check("bp_rdy_back", obuf_rdy, 1'b1);
    check("bp_p_pop1", payload_o, p[2]);
    check("bp_g_after", gnt, 5'b01000);
    tick();
    req = 5'b00001;
    #1;
    check("bp_p_pop2", payload_o, p[3]);
    check("bp_vld_pop2", obuf_vld, 1'b1);
    check("bp_g_wrap", gnt, 5'b00001);
    req = '0;
    tick();
    check("bp_drain_vld", obuf_vld, 1'b0);

    // Reset while full
    link_rdy = 1'b0;
    req = 5'b00001;
    tick();
    tick();
    check("mr_vld_full", obuf_vld, 1'b1);
    check("mr_rdy_full", obuf_rdy, 1'b0);
    req = '0;
    #1;
    rst = 1'b1;
    #1;
    check("mr_vld", obuf_vld, 1'b0);
    check("mr_rdy", obuf_rdy, 1'b1);
    check("mr_pyld", payload_o, 23'h0);
    check("mr_gnt", gnt, 5'b00000);
    rst = 1'b0;
    req = 5'b00100;
    link_rdy = 1'b1;
    #1;
    check("mr_g_post", gnt, 5'b00100);
    tick();
    check("mr_p_post", payload_o, p[2]);
    req = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
